byte_packer: RTL and testbench
==============================

// Module: byte_packer
// PURPOSE
//   Write-side feeder for the dual-clock word buffer; lives in the clk_1 domain.
//   Accepts 8-bit bytes over a valid/ready handshake.
//   Packs byte pairs into 16-bit words and drives the buffer write port
//   (data_1 / data_1_en).
//   Honours buffer_full: holds a completed word and back-pressures the source
//   until space frees.
//   Supports flush, which emits a half-filled word padded with PAD_BYTE.
// PARAMETERS
//   PAD_BYTE   8'h00  filler for the unused byte of a flushed word
//   MSB_FIRST  0      0: first byte -> [7:0], second -> [15:8]; 1: first byte -> [15:8]
//   CNT_W      8      width of word_count
// PORTS
//   clk_1        in   1      only clock; all logic on its rising edge
//   rst_n        in   1      reset: one clock; synchronous, active-low
//   byte_in      in   8      data byte from source
//   byte_valid   in   1      byte_in valid this cycle
//   byte_ready   out  1      packer can accept a byte (combinational)
//   flush        in   1      request emission of a pending half word
//   buffer_full  in   1      downstream buffer full; no write allowed
//   data_1       out  16     packed word to buffer (registered)
//   data_1_en    out  1      one-cycle write strobe for data_1 (registered)
//   word_count   out  CNT_W  number of words written, mod 2^CNT_W
// BEHAVIOUR
//   Accept: byte transferred iff byte_valid & byte_ready at a rising edge.
//   FSM states:
//     IDLE  no byte held.
//     HALF  one byte held.
//     HOLD  full word held, waiting on buffer_full.
//   Transitions:
//     IDLE + accept -> HALF; store byte.
//     HALF + accept, buffer_full=0 -> IDLE; data_1 <= packed word; data_1_en=1 next cycle.
//     HALF + accept, buffer_full=1 -> HOLD; packed word registered; data_1_en stays 0.
//     HALF + flush, no accept, buffer_full=0 -> IDLE; emit word with PAD_BYTE in the empty byte.
//     HALF + flush, no accept, buffer_full=1 -> HOLD with the padded word.
//     HOLD + buffer_full=0 -> IDLE; data_1_en=1 next cycle.
//     HOLD + buffer_full=1 -> remain in HOLD.
//   byte_ready = rst_n & (state != HOLD).
//   Latency: second byte accepted at edge t -> data_1_en high during cycle t+1.
//   data_1_en: high exactly one cycle per word; never two consecutive cycles.
//   data_1: holds its value between writes.
//   word_count: +1 on each data_1_en pulse; wraps 2^CNT_W-1 -> 0.
//   Simultaneous events:
//     Byte accept + flush in HALF: the byte wins; normal word; flush ignored.
//     Flush in IDLE or HOLD: no effect.
//   buffer_full is sampled only at the decision edge. Words are >=2 cycles
//   apart, so the buffer flag always reflects every prior write.
//   Reset (rst_n=0 at an edge):
//     state=IDLE, data_1=16'h0000, data_1_en=0, word_count=0.
//     Held byte or word is discarded.
//     byte_ready=0 while rst_n=0.
//   Reset mid-operation: no partial or held data is ever written after reset.
// TESTING
//   T1 reset, bytes 8'h34 then 8'h12 on consecutive cycles, buffer_full=0
//      -> data_1=16'h1234, data_1_en 1 cycle, word_count=1
//   T2 buffer_full=1, bytes 8'hAB, 8'hCD -> byte_ready=0, data_1_en=0 for 5 cycles;
//      drop buffer_full -> next cycle data_1=16'hCDAB, data_1_en=1, byte_ready=1
//   T3 byte 8'h5A, then flush alone, PAD_BYTE=8'h00 -> data_1=16'h005A, word_count +1;
//      flush in IDLE -> no strobe
//   T4 in HALF (8'h11), flush and byte 8'h22 same cycle -> data_1=16'h2211, single
//      strobe, no pad word
//   T5 byte 8'hEE then rst_n=0 one cycle; then bytes 8'h01, 8'h02 -> only data_1=16'h0201
//      written, word_count=1
//   T6 MSB_FIRST=1: 8'h12, 8'h34 -> 16'h1234; stream 256 words -> word_count wraps to 0

Source files
------------

// File: rtl/byte_packer.sv
// byte_packer
//
// Write-side feeder for the dual-clock word buffer, living entirely in the
// clk_1 domain. Bytes arrive over a valid/ready handshake and are paired into
// 16-bit words that are pushed into the buffer write port. When the buffer
// reports full, a completed word is parked and the source is back-pressured
// until space frees. A flush request closes out a half-filled word, padding
// the missing byte with PAD_BYTE.
//
// Parameters
//   PAD_BYTE    filler for the unused byte of a flushed word
//   MSB_FIRST   0: first byte -> [7:0], second -> [15:8]; 1: first byte -> [15:8]
//   CNT_W       width of word_count
//
// Ports
//   clk_1        in   1      only clock; everything on its rising edge
//   rst_n        in   1      synchronous, active-low reset
//   byte_in      in   8      data byte from the source
//   byte_valid   in   1      byte_in is valid this cycle
//   byte_ready   out  1      packer can accept a byte (combinational)
//   flush        in   1      emit a pending half word, padded
//   buffer_full  in   1      downstream buffer full; no write allowed
//   data_1       out  16     packed word to the buffer (registered)
//   data_1_en    out  1      one-cycle write strobe for data_1 (registered)
//   word_count   out  CNT_W  number of words written, wrapping

module byte_packer #(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter bit         MSB_FIRST = 1'b0,
    parameter int         CNT_W     = 8
) (
    input  logic             clk_1,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             flush,
    input  logic             buffer_full,
    output logic [15:0]      data_1,
    output logic             data_1_en,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  held_byte;
    logic [15:0] pending_word;
    logic        accept;
    logic        store_byte;
    logic        load_pending;
    logic        write_now;
    logic [15:0] write_word;

    // Places the first and second byte of a word according to MSB_FIRST.
    function automatic logic [15:0] pack(input logic [7:0] first,
                                         input logic [7:0] second);
        return MSB_FIRST ? {first, second} : {second, first};
    endfunction

    // While a word is parked in HOLD the source must stall; during reset
    // nothing may be accepted at all.
    assign byte_ready = rst_n & (state != HOLD);
    assign accept     = byte_valid & byte_ready;

    // State register.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. A word completed in HALF either goes
    // straight to the buffer or, if the buffer is full, is parked in
    // pending_word. An incoming byte takes priority over flush in HALF.
    always_comb begin
        next_state   = state;
        store_byte   = 1'b0;
        load_pending = 1'b0;
        write_now    = 1'b0;
        write_word   = pending_word;
        case (state)
            IDLE: begin
                if (accept) begin
                    store_byte = 1'b1;
                    next_state = HALF;
                end
            end
            HALF: begin
                if (accept || flush) begin
                    write_word = accept ? pack(held_byte, byte_in)
                                        : pack(held_byte, PAD_BYTE);
                    if (buffer_full) begin
                        load_pending = 1'b1;
                        next_state   = HOLD;
                    end else begin
                        write_now  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!buffer_full) begin
                    write_now  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath. data_1 only changes together with a strobe, so it keeps the
    // last written word even while another word waits in HOLD. Reset clears
    // held and parked data so nothing stale can be written afterwards.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            held_byte    <= 8'h00;
            pending_word <= 16'h0000;
            data_1       <= 16'h0000;
            data_1_en    <= 1'b0;
            word_count   <= '0;
        end else begin
            data_1_en <= write_now;
            if (store_byte) begin
                held_byte <= byte_in;
            end
            if (load_pending) begin
                pending_word <= write_word;
            end
            if (write_now) begin
                data_1     <= write_word;
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer
//
// Directed bench for byte_packer. Two instances share clock and reset: dut
// uses the default LSB-first packing, dut_m uses MSB_FIRST=1. Inputs change
// and outputs are sampled 1 ns after each rising edge.

module tb_byte_packer;

    logic        clk_1;
    logic        rst_n;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        buffer_full;
    logic [15:0] data_1;
    logic        data_1_en;
    logic [7:0]  word_count;

    logic [7:0]  byte_in_m;
    logic        byte_valid_m;
    logic        byte_ready_m;
    logic        flush_m;
    logic        buffer_full_m;
    logic [15:0] data_1_m;
    logic        data_1_en_m;
    logic [7:0]  word_count_m;

    int checks;
    int fails;

    byte_packer #(.PAD_BYTE(8'h00), .MSB_FIRST(1'b0), .CNT_W(8)) dut (
        .clk_1       (clk_1),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .flush       (flush),
        .buffer_full (buffer_full),
        .data_1      (data_1),
        .data_1_en   (data_1_en),
        .word_count  (word_count)
    );

    byte_packer #(.PAD_BYTE(8'h00), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
        .clk_1       (clk_1),
        .rst_n       (rst_n),
        .byte_in     (byte_in_m),
        .byte_valid  (byte_valid_m),
        .byte_ready  (byte_ready_m),
        .flush       (flush_m),
        .buffer_full (buffer_full_m),
        .data_1      (data_1_m),
        .data_1_en   (data_1_en_m),
        .word_count  (word_count_m)
    );

    // 10 ns clock.
    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (data_1 !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_data_1 got=%h exp=0000", data_1);
        end
        checks++;
        if (data_1_en !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_en got=%b exp=0", data_1_en);
        end
        checks++;
        if (word_count !== 8'd0) begin
            fails++; $display("[TB] FAIL reset_count got=%0d exp=0", word_count);
        end
        checks++;
        if (byte_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_ready got=%b exp=0", byte_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (byte_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL post_reset_ready got=%b exp=1", byte_ready);
        end
    endtask

    task automatic test_pack();
        byte_in = 8'h34; byte_valid = 1'b1;
        tick();
        byte_in = 8'h12;
        tick();
        byte_valid = 1'b0;
        checks++;
        if (data_1_en !== 1'b1 || data_1 !== 16'h1234) begin
            fails++; $display("[TB] FAIL pack_word got en=%b data=%h exp en=1 data=1234", data_1_en, data_1);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0 || data_1 !== 16'h1234 || word_count !== 8'd1) begin
            fails++; $display("[TB] FAIL pack_after got en=%b data=%h cnt=%0d exp en=0 data=1234 cnt=1", data_1_en, data_1, word_count);
        end
    endtask

    task automatic test_backpressure();
        buffer_full = 1'b1;
        byte_in = 8'hAB; byte_valid = 1'b1;
        tick();
        byte_in = 8'hCD;
        tick();
        // Keep offering a byte: it must not be taken while the word is parked.
        byte_in = 8'h99;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (byte_ready !== 1'b0 || data_1_en !== 1'b0) begin
                fails++; $display("[TB] FAIL hold_cycle%0d got ready=%b en=%b exp ready=0 en=0", i, byte_ready, data_1_en);
            end
            tick();
        end
        byte_valid = 1'b0;
        buffer_full = 1'b0;
        tick();
        checks++;
        if (data_1_en !== 1'b1 || data_1 !== 16'hCDAB || byte_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL hold_release got en=%b data=%h ready=%b exp en=1 data=CDAB ready=1", data_1_en, data_1, byte_ready);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0 || word_count !== 8'd2) begin
            fails++; $display("[TB] FAIL hold_after got en=%b cnt=%0d exp en=0 cnt=2", data_1_en, word_count);
        end
    endtask

    task automatic test_flush();
        byte_in = 8'h5A; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (data_1_en !== 1'b1 || data_1 !== 16'h005A) begin
            fails++; $display("[TB] FAIL flush_word got en=%b data=%h exp en=1 data=005A", data_1_en, data_1);
        end
        tick();
        checks++;
        if (word_count !== 8'd3) begin
            fails++; $display("[TB] FAIL flush_count got=%0d exp=3", word_count);
        end
        // Flush with nothing held.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (data_1_en !== 1'b0) begin
            fails++; $display("[TB] FAIL flush_idle_en got=%b exp=0", data_1_en);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0 || word_count !== 8'd3) begin
            fails++; $display("[TB] FAIL flush_idle_after got en=%b cnt=%0d exp en=0 cnt=3", data_1_en, word_count);
        end
    endtask

    task automatic test_flush_with_byte();
        byte_in = 8'h11; byte_valid = 1'b1;
        tick();
        byte_in = 8'h22; flush = 1'b1;
        tick();
        byte_valid = 1'b0; flush = 1'b0;
        checks++;
        if (data_1_en !== 1'b1 || data_1 !== 16'h2211) begin
            fails++; $display("[TB] FAIL byte_beats_flush got en=%b data=%h exp en=1 data=2211", data_1_en, data_1);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0 || word_count !== 8'd4) begin
            fails++; $display("[TB] FAIL byte_flush_after got en=%b cnt=%0d exp en=0 cnt=4", data_1_en, word_count);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0 || data_1 !== 16'h2211 || word_count !== 8'd4) begin
            fails++; $display("[TB] FAIL no_pad_word got en=%b data=%h cnt=%0d exp en=0 data=2211 cnt=4", data_1_en, data_1, word_count);
        end
    endtask

    task automatic test_mid_reset();
        // Reset with a half word held.
        byte_in = 8'hEE; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (data_1 !== 16'h0000 || data_1_en !== 1'b0 || word_count !== 8'd0) begin
            fails++; $display("[TB] FAIL mid_reset got data=%h en=%b cnt=%0d exp data=0000 en=0 cnt=0", data_1, data_1_en, word_count);
        end
        // A flush now must find nothing held.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (data_1_en !== 1'b0 || word_count !== 8'd0) begin
            fails++; $display("[TB] FAIL half_discarded got en=%b cnt=%0d exp en=0 cnt=0", data_1_en, word_count);
        end
        byte_in = 8'h01; byte_valid = 1'b1;
        tick();
        byte_in = 8'h02;
        tick();
        byte_valid = 1'b0;
        checks++;
        if (data_1_en !== 1'b1 || data_1 !== 16'h0201) begin
            fails++; $display("[TB] FAIL after_reset_word got en=%b data=%h exp en=1 data=0201", data_1_en, data_1);
        end
        tick();
        checks++;
        if (word_count !== 8'd1) begin
            fails++; $display("[TB] FAIL after_reset_count got=%0d exp=1", word_count);
        end
        // Reset with a full word parked in HOLD; releasing full must not write it.
        buffer_full = 1'b1;
        byte_in = 8'h77; byte_valid = 1'b1;
        tick();
        byte_in = 8'h88;
        tick();
        byte_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; buffer_full = 1'b0;
        tick();
        checks++;
        if (data_1_en !== 1'b0 || data_1 !== 16'h0000 || word_count !== 8'd0) begin
            fails++; $display("[TB] FAIL hold_discarded got en=%b data=%h cnt=%0d exp en=0 data=0000 cnt=0", data_1_en, data_1, word_count);
        end
        tick();
        checks++;
        if (data_1_en !== 1'b0) begin
            fails++; $display("[TB] FAIL hold_discarded_late got en=%b exp=0", data_1_en);
        end
    endtask

    task automatic test_msb_first_wrap();
        int pulses;
        int back_to_back;
        logic prev_en;
        // The shared resets above leave dut_m idle with a zero count.
        byte_in_m = 8'h12; byte_valid_m = 1'b1;
        tick();
        byte_in_m = 8'h34;
        tick();
        byte_valid_m = 1'b0;
        checks++;
        if (data_1_en_m !== 1'b1 || data_1_m !== 16'h1234) begin
            fails++; $display("[TB] FAIL msb_word got en=%b data=%h exp en=1 data=1234", data_1_en_m, data_1_m);
        end
        byte_in_m = 8'h9C; byte_valid_m = 1'b1;
        tick();
        byte_valid_m = 1'b0; flush_m = 1'b1;
        tick();
        flush_m = 1'b0;
        checks++;
        if (data_1_en_m !== 1'b1 || data_1_m !== 16'h9C00) begin
            fails++; $display("[TB] FAIL msb_flush got en=%b data=%h exp en=1 data=9C00", data_1_en_m, data_1_m);
        end
        tick();
        checks++;
        if (word_count_m !== 8'd2) begin
            fails++; $display("[TB] FAIL msb_count got=%0d exp=2", word_count_m);
        end
        // 254 more words streamed back to back: 2 + 254 = 256 wraps to 0.
        pulses = 0;
        back_to_back = 0;
        prev_en = 1'b0;
        byte_valid_m = 1'b1;
        for (int i = 0; i < 508; i++) begin
            byte_in_m = 8'(i);
            tick();
            if (data_1_en_m) pulses++;
            if (data_1_en_m && prev_en) back_to_back++;
            prev_en = data_1_en_m;
        end
        byte_valid_m = 1'b0;
        tick();
        checks++;
        if (pulses !== 254 || back_to_back !== 0) begin
            fails++; $display("[TB] FAIL stream_pulses got=%0d adjacent=%0d exp 254 adjacent=0", pulses, back_to_back);
        end
        // Last pair streamed was bytes 8'hFA, 8'hFB (i = 506, 507).
        checks++;
        if (data_1_m !== 16'hFAFB) begin
            fails++; $display("[TB] FAIL stream_last got=%h exp=FAFB", data_1_m);
        end
        checks++;
        if (word_count_m !== 8'd0) begin
            fails++; $display("[TB] FAIL count_wrap got=%0d exp=0", word_count_m);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst_n = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; buffer_full = 1'b0;
        byte_in_m = 8'h00; byte_valid_m = 1'b0; flush_m = 1'b0; buffer_full_m = 1'b0;
        #1;
        test_reset();
        test_pack();
        test_backpressure();
        test_flush();
        test_flush_with_byte();
        test_mid_reset();
        test_msb_first_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
